// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: light codes, lamp-driver fault codes and driver states.
// The upstream FSM uses the same light constants.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_ILLEGAL  = 2'b01,
    FAULT_FEEDBACK = 2'b10
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_NIGHT  = 2'd1,
    ST_FAULT  = 2'd2
  } drv_state_e;

  // Exactly one lamp requested; all-off and multi-hot codes are illegal.
  function automatic logic light_is_legal(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/traffic_lamp_driver_if.sv
// Lamp-driver signal bundle: FSM light code and lamp feedback in, lamp enables and fault status out.
interface traffic_lamp_driver_if;

  logic [2:0] light;
  logic       night_mode;
  logic [2:0] lamp_fb;
  logic       fault_clr;
  logic [2:0] lamp;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output light, night_mode, lamp_fb, fault_clr,
    input  lamp, fault, fault_code
  );

  modport slave (
    input  light, night_mode, lamp_fb, fault_clr,
    output lamp, fault, fault_code
  );

endinterface

// File: rtl/traffic_blinker.sv
// Blink phase generator: BLINK_HALF cycles per phase, restartable into the ON phase.
module traffic_blinker #(
  parameter int unsigned BLINK_HALF = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic phase_on,
  output logic wrap_c
);

  localparam int unsigned   CNT_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             phase_nxt;

  assign wrap_c = enable && (cnt == CNT_LAST);

  // Restart wins over counting so every state change begins a fresh ON phase.
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = phase_on;
    if (restart) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b1;
    end else if (wrap_c) begin
      cnt_nxt   = '0;
      phase_nxt = ~phase_on;
    end else if (enable) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else begin
      cnt      <= cnt_nxt;
      phase_on <= phase_nxt;
    end
  end

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp output stage: passes legal light codes, flashes yellow at night, and falls back to
// flashing red when the light code or lamp current-sense stays wrong for too long.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int unsigned BLINK_HALF  = 8,
  parameter int unsigned ILLEGAL_TOL = 2,
  parameter int unsigned FB_TOL      = 4
) (
  input logic                  clk,
  input logic                  reset,
  traffic_lamp_driver_if.slave bus
);

  localparam int unsigned       ILL_W    = $clog2(ILLEGAL_TOL + 1);
  localparam int unsigned       FB_W     = $clog2(FB_TOL + 1);
  localparam logic [ILL_W-1:0]  ILL_LAST = ILL_W'(ILLEGAL_TOL - 1);
  localparam logic [FB_W-1:0]   FB_LAST  = FB_W'(FB_TOL - 1);

  drv_state_e       state_q, state_nxt;
  logic [2:0]       lamp_q, lamp_nxt;
  logic             fault_q, fault_nxt;
  fault_code_e      code_q, code_nxt;
  logic [ILL_W-1:0] ill_cnt, ill_nxt;
  logic [FB_W-1:0]  fb_cnt, fb_nxt;

  logic light_ok, fb_mis, ill_hit, fb_hit;
  logic blink_en, blink_restart, phase_on, wrap_c;

  assign blink_en      = (state_q != ST_NORMAL);
  assign blink_restart = (state_nxt != state_q);

  traffic_blinker #(.BLINK_HALF(BLINK_HALF)) u_blinker (
    .clk      (clk),
    .reset    (reset),
    .enable   (blink_en),
    .restart  (blink_restart),
    .phase_on (phase_on),
    .wrap_c   (wrap_c)
  );

  // Next state, lamp value, detector counters and fault status.
  always_comb begin
    state_nxt = state_q;
    lamp_nxt  = lamp_q;
    fault_nxt = fault_q;
    code_nxt  = code_q;
    ill_nxt   = ill_cnt;
    fb_nxt    = fb_cnt;
    light_ok  = light_is_legal(bus.light);
    fb_mis    = (bus.lamp_fb != lamp_q);
    ill_hit   = !light_ok && (ill_cnt == ILL_LAST);
    fb_hit    = fb_mis && (fb_cnt == FB_LAST);

    case (state_q)
      ST_FAULT: begin
        ill_nxt = '0;
        fb_nxt  = '0;
        if (bus.fault_clr && light_ok) begin
          state_nxt = bus.night_mode ? ST_NIGHT : ST_NORMAL;
          lamp_nxt  = bus.night_mode ? LIGHT_YELLOW : bus.light;
          fault_nxt = 1'b0;
          code_nxt  = FAULT_NONE;
        end else begin
          lamp_nxt = (phase_on ^ wrap_c) ? LIGHT_RED : LIGHT_OFF;
        end
      end
      default: begin
        ill_nxt = light_ok ? '0 : ill_cnt + 1'b1;
        fb_nxt  = fb_mis ? fb_cnt + 1'b1 : '0;
        if (ill_hit || fb_hit) begin
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
          code_nxt  = ill_hit ? FAULT_ILLEGAL : FAULT_FEEDBACK;
          lamp_nxt  = LIGHT_RED;
          ill_nxt   = '0;
          fb_nxt    = '0;
        end else if (bus.night_mode) begin
          state_nxt = ST_NIGHT;
          if (state_q == ST_NIGHT) lamp_nxt = (phase_on ^ wrap_c) ? LIGHT_YELLOW : LIGHT_OFF;
          else                     lamp_nxt = LIGHT_YELLOW;
        end else begin
          state_nxt = ST_NORMAL;
          if (light_ok) lamp_nxt = bus.light;
        end
        // Feedback lags a lamp switch; restart the mismatch run on every change.
        if (lamp_nxt != lamp_q) fb_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_NORMAL;
      lamp_q  <= LIGHT_RED;
      fault_q <= 1'b0;
      code_q  <= FAULT_NONE;
      ill_cnt <= '0;
      fb_cnt  <= '0;
    end else begin
      state_q <= state_nxt;
      lamp_q  <= lamp_nxt;
      fault_q <= fault_nxt;
      code_q  <= code_nxt;
      ill_cnt <= ill_nxt;
      fb_cnt  <= fb_nxt;
    end
  end

  assign bus.lamp       = lamp_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Bench for traffic_lamp_driver: directed scenarios plus random traffic against a behavioural model.
module tb_traffic_lamp_driver;

  localparam int BH  = 4;
  localparam int ITL = 2;
  localparam int FTL = 4;
  localparam int M_NORMAL = 0;
  localparam int M_NIGHT  = 1;
  localparam int M_FAULT  = 2;

  logic clk;
  logic reset;
  logic fb_mirror;
  logic [2:0] fb_force;
  int n_checks;
  int n_pass;

  // Reference model state: mode, outputs, run lengths and cycles since entering a blink mode.
  int m_mode;
  logic [2:0] m_lamp;
  logic m_fault;
  logic [1:0] m_code;
  int m_ill;
  int m_fbm;
  int m_age;

  traffic_lamp_driver_if bus();

  assign bus.lamp_fb = fb_mirror ? bus.lamp : fb_force;

  traffic_lamp_driver #(.BLINK_HALF(BH), .ILLEGAL_TOL(ITL), .FB_TOL(FTL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2:0] blink(input int age, input logic [2:0] on_val);
    return (((age / BH) % 2) == 0) ? on_val : 3'b000;
  endfunction

  function automatic bit legal(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  task automatic model_reset();
    m_mode = M_NORMAL; m_lamp = 3'b100; m_fault = 1'b0; m_code = 2'b00;
    m_ill = 0; m_fbm = 0; m_age = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit lgl, mis, ill_hit, fb_hit;
    logic [2:0] fb, prev;
    lgl = legal(bus.light);
    fb  = fb_mirror ? m_lamp : fb_force;
    if (m_mode == M_FAULT) begin
      if (bus.fault_clr && lgl) begin
        m_mode  = bus.night_mode ? M_NIGHT : M_NORMAL;
        m_lamp  = bus.night_mode ? 3'b010 : bus.light;
        m_fault = 1'b0; m_code = 2'b00; m_age = 0;
      end else begin
        m_age++;
        m_lamp = blink(m_age, 3'b100);
      end
      m_ill = 0; m_fbm = 0;
      return;
    end
    mis     = (fb != m_lamp);
    ill_hit = !lgl && (m_ill + 1 >= ITL);
    fb_hit  = mis && (m_fbm + 1 >= FTL);
    prev    = m_lamp;
    m_ill   = lgl ? 0 : m_ill + 1;
    m_fbm   = mis ? m_fbm + 1 : 0;
    if (ill_hit || fb_hit) begin
      m_mode = M_FAULT; m_fault = 1'b1; m_code = ill_hit ? 2'b01 : 2'b10;
      m_age = 0; m_lamp = 3'b100; m_ill = 0; m_fbm = 0;
    end else if (bus.night_mode) begin
      if (m_mode != M_NIGHT) m_age = 0; else m_age++;
      m_mode = M_NIGHT;
      m_lamp = blink(m_age, 3'b010);
    end else begin
      m_mode = M_NORMAL;
      if (lgl) m_lamp = bus.light;
    end
    if (m_lamp != prev) m_fbm = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.light = 3'b100; bus.night_mode = 1'b0; bus.fault_clr = 1'b0;
    fb_mirror = 1'b1; fb_force = 3'b000;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.lamp, bus.fault, bus.fault_code} !== 6'b100_0_00)
        $display("FAIL reset_hold cyc %0d: lamp=%b fault=%b code=%b, expected 100/0/00",
                 i, bus.lamp, bus.fault, bus.fault_code);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_follow();
    logic [2:0] seq [3];
    seq[0] = 3'b100; seq[1] = 3'b001; seq[2] = 3'b010;
    for (int i = 0; i < 3; i++) begin
      bus.light = seq[i];
      tick();
      n_checks++;
      if ({bus.lamp, bus.fault} !== {seq[i], 1'b0})
        $display("FAIL follow step %0d: lamp=%b fault=%b, expected lamp=%b fault=0",
                 i, bus.lamp, bus.fault, seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_night();
    logic [2:0] exp;
    bus.night_mode = 1'b1;
    bus.light = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = (((i / 4) % 2) == 0) ? 3'b010 : 3'b000;
      n_checks++;
      if ({bus.lamp, bus.fault, bus.lamp} !== {exp, 1'b0, m_lamp})
        $display("FAIL night_blink cyc %0d: lamp=%b fault=%b, expected lamp=%b (model %b) fault=0",
                 i, bus.lamp, bus.fault, exp, m_lamp);
      else n_pass++;
    end
    bus.night_mode = 1'b0;
    bus.light = 3'b001;
    tick();
    n_checks++;
    if (bus.lamp !== 3'b001)
      $display("FAIL night_exit: lamp=%b, expected 001", bus.lamp);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bus.light = 3'b001; tick();
    bus.light = 3'b011; tick();
    n_checks++;
    if ({bus.lamp, bus.fault} !== 4'b001_0)
      $display("FAIL illegal_hold: lamp=%b fault=%b, expected lamp=001 fault=0", bus.lamp, bus.fault);
    else n_pass++;
    bus.light = 3'b001; tick();
    bus.light = 3'b000; tick();
    n_checks++;
    if ({bus.lamp, bus.fault} !== 4'b001_0)
      $display("FAIL illegal_first: lamp=%b fault=%b, expected lamp=001 fault=0", bus.lamp, bus.fault);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.lamp, bus.fault, bus.fault_code} !== 6'b100_1_01)
      $display("FAIL illegal_fault: lamp=%b fault=%b code=%b, expected 100/1/01",
               bus.lamp, bus.fault, bus.fault_code);
    else n_pass++;
    bus.light = 3'b010;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_checks++;
      if ({bus.lamp, bus.fault, bus.fault_code} !== {blink(i, 3'b100), 1'b1, 2'b01})
        $display("FAIL fault_blink age %0d: lamp=%b fault=%b code=%b, expected lamp=%b fault=1 code=01",
                 i, bus.lamp, bus.fault, bus.fault_code, blink(i, 3'b100));
      else n_pass++;
    end
  endtask

  task automatic test_fault_clr();
    bus.light = 3'b110; bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0;
    n_checks++;
    if ({bus.fault, bus.fault_code} !== 3'b1_01)
      $display("FAIL clr_illegal_ignored: fault=%b code=%b, expected fault=1 code=01", bus.fault, bus.fault_code);
    else n_pass++;
    bus.light = 3'b010; bus.night_mode = 1'b0; bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0;
    n_checks++;
    if ({bus.lamp, bus.fault, bus.fault_code} !== 6'b010_0_00)
      $display("FAIL clr_exit: lamp=%b fault=%b code=%b, expected 010/0/00",
               bus.lamp, bus.fault, bus.fault_code);
    else n_pass++;
    bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0;
    n_checks++;
    if ({bus.lamp, bus.fault} !== 4'b010_0)
      $display("FAIL clr_outside_fault: lamp=%b fault=%b, expected lamp=010 fault=0", bus.lamp, bus.fault);
    else n_pass++;
  endtask

  task automatic test_feedback();
    bus.light = 3'b001; tick();
    fb_mirror = 1'b0; fb_force = 3'b000;
    for (int i = 0; i < 3; i++) tick();
    fb_mirror = 1'b1; tick();
    n_checks++;
    if ({bus.lamp, bus.fault} !== 4'b001_0)
      $display("FAIL fb_short_run: lamp=%b fault=%b, expected lamp=001 fault=0", bus.lamp, bus.fault);
    else n_pass++;
    fb_mirror = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.fault !== 1'b0)
      $display("FAIL fb_before_tol: fault=%b, expected 0", bus.fault);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.lamp, bus.fault, bus.fault_code} !== 6'b100_1_10)
      $display("FAIL fb_fault: lamp=%b fault=%b code=%b, expected 100/1/10",
               bus.lamp, bus.fault, bus.fault_code);
    else n_pass++;
    fb_mirror = 1'b1;
    bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0;
    n_checks++;
    if ({bus.lamp, bus.fault, bus.fault_code} !== 6'b001_0_00)
      $display("FAIL fb_clear: lamp=%b fault=%b code=%b, expected 001/0/00",
               bus.lamp, bus.fault, bus.fault_code);
    else n_pass++;
  endtask

  task automatic test_reset_in_fault();
    bus.light = 3'b000; tick(); tick();
    bus.light = 3'b100;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({bus.lamp, bus.fault, bus.fault_code} !== {m_lamp, m_fault, m_code} || bus.lamp !== 3'b000)
      $display("FAIL pre_reset_blink: lamp=%b fault=%b code=%b, expected lamp=000 fault=1 code=01",
               bus.lamp, bus.fault, bus.fault_code);
    else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.lamp, bus.fault, bus.fault_code} !== 6'b100_0_00)
      $display("FAIL async_reset: lamp=%b fault=%b code=%b, expected 100/0/00",
               bus.lamp, bus.fault, bus.fault_code);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int burst;
    burst = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: bus.light = 3'b100;
        3, 4, 5: bus.light = 3'b001;
        6, 7:    bus.light = 3'b010;
        default: bus.light = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 15) == 0) bus.night_mode = ~bus.night_mode;
      bus.fault_clr = ($urandom_range(0, 5) == 0);
      if (burst > 0) burst--;
      else if ($urandom_range(0, 29) == 0) burst = $urandom_range(1, 6);
      fb_mirror = (burst == 0);
      fb_force  = 3'($urandom_range(0, 7));
      tick();
      n_checks++;
      if ({bus.lamp, bus.fault, bus.fault_code} !== {m_lamp, m_fault, m_code})
        $display("FAIL random cyc %0d: lamp=%b fault=%b code=%b, expected lamp=%b fault=%b code=%b",
                 i, bus.lamp, bus.fault, bus.fault_code, m_lamp, m_fault, m_code);
      else n_pass++;
    end
    bus.fault_clr = 1'b0;
    fb_mirror = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_follow();
    test_night();
    test_illegal();
    test_fault_clr();
    test_feedback();
    test_reset_in_fault();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
Output stage directly downstream of the traffic-light FSM. It consumes the FSM's one-hot light code (bit 2 red, bit 1 yellow, bit 0 green) and drives the physical lamp enables. It adds a night-mode flashing-yellow override, validates the FSM code and the lamp current-sense feedback, and falls back to flashing red on any fault.

Parameters:
BLINK_HALF, 8, cycles per blink phase (on or off) in NIGHT and FAULT; must be at least 2.
ILLEGAL_TOL, 2, consecutive cycles of an illegal light code that trigger a fault; must be at least 1.
FB_TOL, 4, consecutive cycles of lamp/feedback mismatch that trigger a fault; must be at least 2.

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high reset
light  input  3  one-hot code from the FSM: 100 red, 010 yellow, 001 green
night_mode  input  1  level; requests flashing-yellow operation
lamp_fb  input  3  synchronous lamp current-sense, same bit order as lamp
fault_clr  input  1  single-cycle pulse; requests exit from FAULT
lamp  output  3  registered lamp enables
fault  output  1  registered; high while in FAULT
fault_code  output  2  registered; 00 none, 01 illegal light code, 10 lamp feedback mismatch

Behaviour:
- Reset (asynchronous, active-high): state NORMAL, lamp=100 (red, safe), fault=0, fault_code=00, all counters 0, blink phase ON.
- All outputs are registered. Outputs change only on a clock edge, except under reset.
- Legal light codes are exactly 100, 010 and 001. The codes 000 and any multi-hot code are illegal.
- States are NORMAL, NIGHT and FAULT. Priority is FAULT > NIGHT > NORMAL.
- NORMAL: lamp = light with 1-cycle latency. If night_mode=1 is sampled, go to NIGHT.
- NIGHT: lamp toggles between 010 and 000. Phases last BLINK_HALF cycles each.
  - On entry, the blink counter clears and lamp=010 from the entry edge.
  - Sampling night_mode=0 returns to NORMAL. lamp = the light value sampled at that edge.
- Illegal-code detection is active in NORMAL and NIGHT:
  - The counter increments on each illegal sample and clears on any legal sample.
  - The edge that samples the ILLEGAL_TOL-th consecutive illegal value enters FAULT with fault_code=01.
  - While the count is below ILLEGAL_TOL in NORMAL, lamp holds its previous value. An illegal code is never passed to lamp.
- Feedback check is active in NORMAL and NIGHT:
  - Compares lamp_fb against the current lamp register each cycle.
  - The counter increments on mismatch and clears on match. It also clears on every lamp change, to cover the lamp switching transient.
  - The edge that samples the FB_TOL-th consecutive mismatch enters FAULT with fault_code=10.
- If both faults trigger on the same edge, fault_code=01.
- FAULT:
  - fault=1. fault_code is latched and keeps the first cause.
  - lamp flashes red, toggling between 100 and 000 with BLINK_HALF-cycle phases, starting ON at the entry edge.
  - Both detectors are frozen and cleared. night_mode is ignored.
- FAULT exit:
  - A fault_clr pulse is honored only if light is legal in the same cycle.
  - On that edge: fault=0, fault_code=00, counters clear, and the next state is NIGHT if night_mode=1, else NORMAL. lamp takes the corresponding value (010, or the sampled light).
  - A fault_clr sampled outside FAULT, or with an illegal light code, is ignored.
- Blink counter: width clog2(BLINK_HALF). It wraps from BLINK_HALF-1 to 0 and toggles the phase on the wrap. It clears on every state change.
- Reset asserted mid-operation, including mid-blink or in FAULT, immediately forces the reset values listed above.

Decomposition:
- Shared package traffic_pkg: light codes LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001, LIGHT_OFF=3'b000; fault code constants; driver state encoding. The upstream FSM adopts the same light constants.
- One natural sub-module: traffic_blinker. It holds the BLINK_HALF counter and phase flop, with an enable and a synchronous restart input, and outputs phase_on.

Test Plan:
(BLINK_HALF=4, ILLEGAL_TOL=2, FB_TOL=4; lamp_fb mirrors lamp unless stated.)
- Reset, then light sequence 100, 001, 010 -> lamp=100 during reset; lamp follows light one cycle later; fault stays 0.
- night_mode=1 for 20 cycles -> lamp 010 for 4 cycles, 000 for 4 cycles, repeating; night_mode=0 with light=001 -> lamp=001 at the next edge.
- Single-cycle light=011 -> lamp holds its previous value, no fault. Two consecutive 000 cycles -> fault=1, fault_code=01, lamp blinks 100/000 every 4 cycles.
- Force lamp_fb=000 while lamp=001 for 4 cycles -> fault=1, fault_code=10. A 3-cycle mismatch followed by a match -> no fault.
- In FAULT: fault_clr with light=110 -> ignored. fault_clr with light=010 and night_mode=0 -> fault=0, fault_code=00, lamp=010 next cycle.
- Assert reset mid-blink in FAULT -> lamp=100, fault=0, fault_code=00 immediately, without waiting for a clock edge.
